// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with branch/jump resolution, one-shot PC redirect and flush.
// Optional branch statistics counters are built when EX_MEM_BRANCH_STATS_EN is defined.
module ex_mem_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            ex_valid,
  input  logic [XLEN-1:0] ALUResult,
  input  logic            Zero,
  input  logic            Less,
  input  logic [XLEN-1:0] ex_store_data,
  input  logic [4:0]      ex_rd,
  input  logic            ex_RegWrite,
  input  logic            ex_MemRead,
  input  logic            ex_MemWrite,
  input  logic            ex_MemtoReg,
  input  logic            ex_Branch,
  input  logic            ex_Jump,
  input  logic            ex_Jalr,
  input  logic [2:0]      ex_funct3,
  input  logic [XLEN-1:0] ex_target,
  input  logic [XLEN-1:0] ex_pc_plus4,
  output logic            mem_valid,
  output logic [XLEN-1:0] ALUResult_EX_MEM_out,
  output logic [XLEN-1:0] mem_store_data,
  output logic [XLEN-1:0] mem_pc_plus4,
  output logic [4:0]      mem_rd,
  output logic [2:0]      mem_funct3,
  output logic            mem_RegWrite,
  output logic            mem_MemRead,
  output logic            mem_MemWrite,
  output logic            mem_MemtoReg,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_o,
  output logic [31:0]     br_count,
  output logic [31:0]     br_taken_count
);

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
    logic jump;
    logic jalr;
  } ctl_t;

  typedef enum logic {IDLE, FIRED} rd_state_t;

  ctl_t            ex_ctl, mem_ctl;
  logic            zero_q, less_q;
  logic [XLEN-1:0] target_q;
  rd_state_t       rd_state;
  logic            redirect_done;
  logic            br_cond, taken;

  assign ex_ctl = ex_valid ? '{ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg,
                               ex_Branch, ex_Jump, ex_Jalr} : '0;

  // Stall holds everything; a redirecting instruction turns the next capture into a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_valid            <= 1'b0;
      mem_ctl              <= '0;
      ALUResult_EX_MEM_out <= '0;
      mem_store_data       <= '0;
      mem_pc_plus4         <= '0;
      mem_rd               <= '0;
      mem_funct3           <= '0;
      zero_q               <= 1'b0;
      less_q               <= 1'b0;
      target_q             <= '0;
    end else if (!stall_i) begin
      mem_valid            <= ex_valid & ~redirect_o;
      mem_ctl              <= redirect_o ? '0 : ex_ctl;
      ALUResult_EX_MEM_out <= ALUResult;
      mem_store_data       <= ex_store_data;
      mem_pc_plus4         <= ex_pc_plus4;
      mem_rd               <= ex_rd;
      mem_funct3           <= ex_funct3;
      zero_q               <= Zero;
      less_q               <= Less;
      target_q             <= ex_target;
    end
  end

  // Remembers that a stalled instruction already redirected, so it fires only once.
  always_ff @(posedge clk) begin
    if (!rst_n) rd_state <= IDLE;
    else begin
      case (rd_state)
        IDLE:    if (redirect_o && stall_i) rd_state <= FIRED;
        FIRED:   if (!stall_i) rd_state <= IDLE;
        default: rd_state <= IDLE;
      endcase
    end
  end

  assign redirect_done = (rd_state == FIRED);

  always_comb begin
    br_cond = 1'b0;
    case (mem_funct3)
      3'b000:          br_cond = zero_q;
      3'b001:          br_cond = ~zero_q;
      3'b100, 3'b110:  br_cond = less_q;
      3'b101, 3'b111:  br_cond = ~less_q;
      default:         br_cond = 1'b0;
    endcase
  end

  assign taken        = mem_ctl.jump | (mem_ctl.branch & br_cond);
  assign redirect_o   = mem_valid & taken & ~redirect_done;
  assign flush_o      = redirect_o;
  assign redirect_pc  = redirect_o ? {target_q[XLEN-1:1], target_q[0] & ~mem_ctl.jalr} : '0;

  assign mem_RegWrite = mem_ctl.reg_write;
  assign mem_MemRead  = mem_ctl.mem_read;
  assign mem_MemWrite = mem_ctl.mem_write;
  assign mem_MemtoReg = mem_ctl.mem_to_reg;

`ifdef EX_MEM_BRANCH_STATS_EN
  logic        fresh_q;
  logic [31:0] br_cnt_q, tk_cnt_q;

  // fresh_q marks the first cycle an instruction sits in the stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fresh_q  <= 1'b0;
      br_cnt_q <= '0;
      tk_cnt_q <= '0;
    end else begin
      fresh_q <= ~stall_i;
      if (mem_valid && (mem_ctl.branch || mem_ctl.jump) && fresh_q && !redirect_done)
        br_cnt_q <= br_cnt_q + 32'd1;
      if (redirect_o)
        tk_cnt_q <= tk_cnt_q + 32'd1;
    end
  end

  assign br_count       = br_cnt_q;
  assign br_taken_count = tk_cnt_q;
`else
  assign br_count       = '0;
  assign br_taken_count = '0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Table-driven bench for ex_mem_stage with a queue of expected post-edge states,
// plus a hand-written branch statistics sequence.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n, stall_i, ex_valid, Zero, Less;
  logic [31:0] ALUResult, ex_store_data, ex_target, ex_pc_plus4;
  logic [4:0]  ex_rd;
  logic        ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg, ex_Branch, ex_Jump, ex_Jalr;
  logic [2:0]  ex_funct3;
  logic        mem_valid, mem_RegWrite, mem_MemRead, mem_MemWrite, mem_MemtoReg;
  logic [31:0] ALUResult_EX_MEM_out, mem_store_data, mem_pc_plus4, redirect_pc;
  logic [4:0]  mem_rd;
  logic [2:0]  mem_funct3;
  logic        redirect_o, flush_o;
  logic [31:0] br_count, br_taken_count;

  ex_mem_stage #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .ex_valid(ex_valid),
    .ALUResult(ALUResult), .Zero(Zero), .Less(Less), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_RegWrite(ex_RegWrite), .ex_MemRead(ex_MemRead),
    .ex_MemWrite(ex_MemWrite), .ex_MemtoReg(ex_MemtoReg), .ex_Branch(ex_Branch),
    .ex_Jump(ex_Jump), .ex_Jalr(ex_Jalr), .ex_funct3(ex_funct3), .ex_target(ex_target),
    .ex_pc_plus4(ex_pc_plus4), .mem_valid(mem_valid),
    .ALUResult_EX_MEM_out(ALUResult_EX_MEM_out), .mem_store_data(mem_store_data),
    .mem_pc_plus4(mem_pc_plus4), .mem_rd(mem_rd), .mem_funct3(mem_funct3),
    .mem_RegWrite(mem_RegWrite), .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
    .mem_MemtoReg(mem_MemtoReg), .redirect_o(redirect_o), .redirect_pc(redirect_pc),
    .flush_o(flush_o), .br_count(br_count), .br_taken_count(br_taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst, stall, valid;
    logic [31:0] alu;
    logic        zero, less;
    logic [4:0]  rd;
    logic        rw, m, br, jmp, jalr;
    logic [2:0]  f3;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] ealu;
    logic [4:0]  erd;
    logic        erw, em, eredir;
    logic [31:0] erpc;
  } vec_t;

  typedef struct {
    string       nm;
    logic        chk_data, ev, erw, em, eredir, rst;
    logic [31:0] ealu, esd, epc4, erpc;
    logic [4:0]  erd;
  } exp_t;

  int   n_vec = 0, n_err = 0;
  vec_t tbl[26];
  exp_t sb[$];
  logic [31:0] m_sd = 0, m_pc4 = 0;
  logic [31:0] exp_br, exp_tk;

  function automatic vec_t v(input string nm, input logic rst, input logic stall,
      input logic valid, input logic [31:0] alu, input logic zero, input logic less,
      input logic [4:0] rd, input logic rw, input logic m, input logic br, input logic jmp,
      input logic jalr, input logic [2:0] f3, input logic [31:0] tgt, input logic ev,
      input logic [31:0] ealu, input logic [4:0] erd, input logic erw, input logic em,
      input logic eredir, input logic [31:0] erpc);
    vec_t t;
    t.nm = nm; t.rst = rst; t.stall = stall; t.valid = valid; t.alu = alu; t.zero = zero;
    t.less = less; t.rd = rd; t.rw = rw; t.m = m; t.br = br; t.jmp = jmp; t.jalr = jalr;
    t.f3 = f3; t.tgt = tgt; t.ev = ev; t.ealu = ealu; t.erd = erd; t.erw = erw; t.em = em;
    t.eredir = eredir; t.erpc = erpc;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic stall, input logic valid,
      input logic [31:0] alu, input logic zero, input logic less, input logic [4:0] rd,
      input logic rw, input logic m, input logic br, input logic jmp, input logic jalr,
      input logic [2:0] f3, input logic [31:0] tgt);
    rst_n = rst; stall_i = stall; ex_valid = valid; ALUResult = alu; Zero = zero; Less = less;
    ex_rd = rd; ex_RegWrite = rw; ex_MemRead = m; ex_MemWrite = m; ex_MemtoReg = m;
    ex_Branch = br; ex_Jump = jmp; ex_Jalr = jalr; ex_funct3 = f3; ex_target = tgt;
    ex_store_data = ~alu; ex_pc_plus4 = alu + 32'd4;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    //                       rst st vl alu         z  l  rd  rw m  br j  jr f3      tgt        ev ealu        erd rw m  rd rpc
    tbl[0]  = v("reset1",    0, 0, 1, 32'hdead,   1, 1, 31, 1, 1, 1, 1, 0, 3'b000, 32'h80,    0, 0,          0, 0, 0, 0, 0);
    tbl[1]  = v("reset2",    0, 0, 1, 32'hdead,   1, 1, 31, 1, 1, 1, 1, 0, 3'b000, 32'h80,    0, 0,          0, 0, 0, 0, 0);
    tbl[2]  = v("capture",   1, 0, 1, 32'h1234,   0, 0, 5,  1, 0, 0, 0, 0, 3'b010, 32'h0,     1, 32'h1234,   5, 1, 0, 0, 0);
    tbl[3]  = v("invalid",   1, 0, 0, 32'h55,     1, 0, 7,  1, 1, 1, 1, 0, 3'b000, 32'h44,    0, 0,          0, 0, 0, 0, 0);
    tbl[4]  = v("memop",     1, 0, 1, 32'h40,     0, 0, 3,  0, 1, 0, 0, 0, 3'b010, 32'h0,     1, 32'h40,     3, 0, 1, 0, 0);
    tbl[5]  = v("beq_tk",    1, 0, 1, 32'h0,      1, 0, 0,  0, 0, 1, 0, 0, 3'b000, 32'h100,   1, 32'h0,      0, 0, 0, 1, 32'h100);
    tbl[6]  = v("killed",    1, 0, 1, 32'h77,     0, 0, 9,  1, 1, 0, 0, 0, 3'b000, 32'h0,     0, 0,          0, 0, 0, 0, 0);
    tbl[7]  = v("after_kill",1, 0, 1, 32'h88,     0, 0, 10, 1, 0, 0, 0, 0, 3'b000, 32'h0,     1, 32'h88,     10, 1, 0, 0, 0);
    tbl[8]  = v("blt_nt",    1, 0, 1, 32'h8,      1, 0, 0,  0, 0, 1, 0, 0, 3'b100, 32'h200,   1, 32'h8,      0, 0, 0, 0, 0);
    tbl[9]  = v("after_nt",  1, 0, 1, 32'h99,     0, 0, 11, 1, 0, 0, 0, 0, 3'b000, 32'h0,     1, 32'h99,     11, 1, 0, 0, 0);
    tbl[10] = v("bne_tk",    1, 0, 1, 32'h10,     0, 1, 0,  0, 0, 1, 0, 0, 3'b001, 32'h300,   1, 32'h10,     0, 0, 0, 1, 32'h300);
    tbl[11] = v("b2b_kill",  1, 0, 1, 32'h14,     1, 0, 0,  0, 0, 1, 0, 0, 3'b000, 32'h400,   0, 0,          0, 0, 0, 0, 0);
    tbl[12] = v("jal",       1, 0, 1, 32'h504,    0, 0, 1,  1, 0, 0, 1, 0, 3'b010, 32'h500,   1, 32'h504,    1, 1, 0, 1, 32'h500);
    tbl[13] = v("jal_kill",  1, 0, 0, 32'h18,     0, 0, 0,  0, 0, 0, 1, 0, 3'b000, 32'h900,   0, 0,          0, 0, 0, 0, 0);
    tbl[14] = v("jalr",      1, 0, 1, 32'haaaa,   0, 0, 1,  1, 0, 0, 1, 1, 3'b000, 32'h203,   1, 32'haaaa,   1, 1, 0, 1, 32'h202);
    tbl[15] = v("stall1",    1, 1, 1, 32'hbbbb,   1, 0, 2,  0, 1, 1, 0, 0, 3'b000, 32'h700,   1, 32'haaaa,   1, 1, 0, 0, 0);
    tbl[16] = v("stall2",    1, 1, 1, 32'hcccc,   1, 0, 2,  0, 1, 1, 0, 0, 3'b000, 32'h700,   1, 32'haaaa,   1, 1, 0, 0, 0);
    tbl[17] = v("stall3",    1, 1, 1, 32'hdddd,   1, 0, 2,  0, 1, 1, 0, 0, 3'b000, 32'h700,   1, 32'haaaa,   1, 1, 0, 0, 0);
    tbl[18] = v("post_stall",1, 0, 0, 32'h1c,     0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 32'h0,     0, 0,          0, 0, 0, 0, 0);
    tbl[19] = v("beq_pre_rst",1,0, 1, 32'h20,     1, 0, 0,  0, 0, 1, 0, 0, 3'b000, 32'h600,   1, 32'h20,     0, 0, 0, 1, 32'h600);
    tbl[20] = v("rst_mid",   0, 1, 1, 32'h24,     1, 0, 6,  1, 1, 1, 0, 0, 3'b000, 32'h600,   0, 0,          0, 0, 0, 0, 0);
    tbl[21] = v("post_rst",  1, 0, 1, 32'h42,     0, 0, 4,  1, 0, 0, 0, 0, 3'b000, 32'h0,     1, 32'h42,     4, 1, 0, 0, 0);
    tbl[22] = v("bgeu_tk",   1, 0, 1, 32'h28,     1, 0, 0,  0, 0, 1, 0, 0, 3'b111, 32'h700,   1, 32'h28,     0, 0, 0, 1, 32'h700);
    tbl[23] = v("bubble",    1, 0, 0, 32'h2c,     0, 0, 0,  0, 0, 0, 0, 0, 3'b000, 32'h0,     0, 0,          0, 0, 0, 0, 0);
    tbl[24] = v("f3_010_nt", 1, 0, 1, 32'h30,     1, 1, 0,  0, 0, 1, 0, 0, 3'b010, 32'h800,   1, 32'h30,     0, 0, 0, 0, 0);
    tbl[25] = v("bge_nt",    1, 0, 1, 32'h34,     0, 1, 8,  1, 0, 1, 0, 0, 3'b101, 32'h900,   1, 32'h34,     8, 1, 0, 0, 0);

    tick();
    foreach (tbl[i]) begin
      exp_t e;
      vec_t t;
      t = tbl[i];
      drive(t.rst, t.stall, t.valid, t.alu, t.zero, t.less, t.rd, t.rw, t.m, t.br, t.jmp,
            t.jalr, t.f3, t.tgt);
      if (!t.rst) begin m_sd = 0; m_pc4 = 0; end
      else if (!t.stall) begin m_sd = ~t.alu; m_pc4 = t.alu + 32'd4; end
      e.nm = t.nm; e.ev = t.ev; e.erw = t.erw; e.em = t.em; e.eredir = t.eredir;
      e.erpc = t.erpc; e.ealu = t.ealu; e.erd = t.erd; e.esd = m_sd; e.epc4 = m_pc4;
      e.rst = !t.rst; e.chk_data = t.ev | !t.rst;
      sb.push_back(e);
      tick();
      e = sb.pop_front();
      chk({e.nm, ".valid"}, {31'd0, mem_valid}, {31'd0, e.ev});
      chk({e.nm, ".regwrite"}, {31'd0, mem_RegWrite}, {31'd0, e.erw});
      chk({e.nm, ".memctl"}, {29'd0, mem_MemRead, mem_MemWrite, mem_MemtoReg}, {29'd0, {3{e.em}}});
      chk({e.nm, ".redirect"}, {30'd0, redirect_o, flush_o}, {30'd0, e.eredir, e.eredir});
      chk({e.nm, ".redirect_pc"}, redirect_pc, e.erpc);
      if (e.chk_data) begin
        chk({e.nm, ".alu"}, ALUResult_EX_MEM_out, e.ealu);
        chk({e.nm, ".rd"}, {27'd0, mem_rd}, {27'd0, e.erd});
        chk({e.nm, ".store_data"}, mem_store_data, e.esd);
        chk({e.nm, ".pc_plus4"}, mem_pc_plus4, e.epc4);
      end
      if (e.rst) begin
        chk({e.nm, ".funct3"}, {29'd0, mem_funct3}, 32'd0);
        chk({e.nm, ".br_count"}, br_count, 32'd0);
        chk({e.nm, ".br_taken_count"}, br_taken_count, 32'd0);
      end
    end

    // Statistics: three branches, two taken, the second taken one stalled two cycles.
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);                 tick();
    drive(1, 0, 1, 32'h0, 1, 0, 0, 0, 0, 1, 0, 0, 3'b000, 32'h100);  tick();
    drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0);    tick();
    drive(1, 0, 1, 32'h0, 1, 0, 0, 0, 0, 1, 0, 0, 3'b001, 32'h200);  tick();
    chk("stats.bne_no_redirect", {31'd0, redirect_o}, 32'd0);
    drive(1, 0, 1, 32'h0, 0, 0, 1, 1, 0, 0, 1, 0, 3'b000, 32'h300);  tick();
    chk("stats.jal_redirect", {31'd0, redirect_o}, 32'd1);
    drive(1, 1, 1, 32'h5, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 32'h0);    tick();
    chk("stats.stall_once", {31'd0, redirect_o}, 32'd0);
    drive(1, 1, 1, 32'h5, 0, 0, 0, 0, 0, 1, 0, 0, 3'b000, 32'h0);    tick();
    chk("stats.stall_held", {31'd0, mem_valid}, 32'd1);
    drive(1, 0, 0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 0, 3'b000, 32'h0);    tick();
    chk("stats.post_stall_bubble", {31'd0, mem_valid}, 32'd0);
`ifdef EX_MEM_BRANCH_STATS_EN
    exp_br = 32'd3; exp_tk = 32'd2;
`else
    exp_br = 32'd0; exp_tk = 32'd0;
`endif
    chk("stats.br_count", br_count, exp_br);
    chk("stats.br_taken_count", br_taken_count, exp_tk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
